// File: rtl/johnson_seq_monitor.sv
// johnson_seq_monitor
//   Integrity monitor for a WIDTH-bit Johnson counter. Every rising edge it
//   decodes counter_state to a phase index. It flags codes that are not legal
//   Johnson codes and legal codes that arrive out of sequence. It also keeps
//   a saturating error count and a sticky alarm for the security logic.
//
// Ports
//   clock          in   sole clock, rising edge
//   reset          in   asynchronous active-low reset
//   counter_state  in   [WIDTH-1:0] Johnson counter output, sampled each edge
//   clear          in   synchronous clear of err_count / alarm
//   phase          out  [PHASE_W-1:0] phase of the last legal sample
//   phase_valid    out  last sample was a legal code
//   illegal_state  out  one-cycle pulse: last sample was an illegal code
//   seq_error      out  one-cycle pulse: last sample legal but out of sequence
//   err_count      out  [CNT_W-1:0] saturating error-event count
//   alarm          out  sticky, set when err_count reaches ERR_THRESHOLD
module johnson_seq_monitor #(
    parameter int WIDTH         = 4,
    parameter int ERR_THRESHOLD = 3,
    parameter int CNT_W         = 8,
    localparam int PHASE_W      = $clog2(2 * WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   counter_state,
    input  logic               clear,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               illegal_state,
    output logic               seq_error,
    output logic [CNT_W-1:0]   err_count,
    output logic               alarm
);

    localparam int unsigned CYCLE = 2 * WIDTH;

    logic [PHASE_W-1:0] prev_phase;
    logic               have_prev;

    logic               dec_legal;
    logic [PHASE_W-1:0] dec_phase;
    logic [PHASE_W-1:0] succ_phase;
    logic               ill_hit;
    logic               seq_hit;
    logic               err_event;
    logic [CNT_W-1:0]   cnt_next;
    logic               alarm_next;

    // Johnson code for phase k: k ones in the LSBs for k < WIDTH, otherwise
    // (2*WIDTH - k) ones in the MSBs.
    function automatic logic [WIDTH-1:0] code_of(input int unsigned k);
        logic [WIDTH-1:0] all_ones;
        all_ones = '1;
        if (k < WIDTH)
            return ~(all_ones << k);
        else
            return all_ones << (k - WIDTH);
    endfunction

    // Decode: at most one phase matches a given code.
    always_comb begin
        dec_legal = 1'b0;
        dec_phase = '0;
        for (int unsigned k = 0; k < CYCLE; k++) begin
            if (counter_state == code_of(k)) begin
                dec_legal = 1'b1;
                dec_phase = PHASE_W'(k);
            end
        end
    end

    // Expected successor of the previous legal phase, wrapping at 2*WIDTH.
    always_comb begin
        succ_phase = '0;
        if (prev_phase != PHASE_W'(CYCLE - 1))
            succ_phase = prev_phase + PHASE_W'(1);
    end

    // Phase 0 is always accepted: the counter may have been reset, or it may
    // be held in reset and repeating its zero code.
    always_comb begin
        ill_hit   = ~dec_legal;
        seq_hit   = dec_legal & have_prev &
                    (dec_phase != '0) & (dec_phase != succ_phase);
        err_event = ill_hit | seq_hit;
    end

    // Error counter and alarm. A clear restarts the count from this cycle's
    // event, and the alarm is re-evaluated against the restarted count.
    always_comb begin
        cnt_next = err_count;
        if (clear)
            cnt_next = CNT_W'(err_event);
        else if (err_event && (err_count != '1))
            cnt_next = err_count + CNT_W'(1);

        alarm_next = (alarm & ~clear) |
                     (cnt_next >= CNT_W'(ERR_THRESHOLD));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_phase    <= '0;
            have_prev     <= 1'b0;
            phase         <= '0;
            phase_valid   <= 1'b0;
            illegal_state <= 1'b0;
            seq_error     <= 1'b0;
            err_count     <= '0;
            alarm         <= 1'b0;
        end else begin
            illegal_state <= ill_hit;
            seq_error     <= seq_hit;
            phase_valid   <= dec_legal;
            err_count     <= cnt_next;
            alarm         <= alarm_next;
            if (dec_legal) begin
                // Both accepted and out-of-sequence samples resynchronise.
                phase      <= dec_phase;
                prev_phase <= dec_phase;
                have_prev  <= 1'b1;
            end else begin
                have_prev  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_johnson_seq_monitor.sv
module tb_johnson_seq_monitor;

    typedef struct {
        int ph;
        int pv;
        int ill;
        int sq;
        int cnt;
        int al;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [3:0] counter_state;
    logic       clear;
    logic [2:0] phase;
    logic       phase_valid;
    logic       illegal_state;
    logic       seq_error;
    logic [7:0] err_count;
    logic       alarm;

    logic [3:0] cs1;
    logic       clr1;
    logic [2:0] phase1;
    logic       pv1;
    logic       ill1;
    logic       seq1;
    logic [1:0] cnt1;
    logic       alarm1;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t q0[$];
    exp_t q1[$];

    johnson_seq_monitor #(.WIDTH(4), .ERR_THRESHOLD(3), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .counter_state(counter_state),
        .clear(clear), .phase(phase), .phase_valid(phase_valid),
        .illegal_state(illegal_state), .seq_error(seq_error),
        .err_count(err_count), .alarm(alarm)
    );

    johnson_seq_monitor #(.WIDTH(4), .ERR_THRESHOLD(3), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .counter_state(cs1),
        .clear(clr1), .phase(phase1), .phase_valid(pv1),
        .illegal_state(ill1), .seq_error(seq1),
        .err_count(cnt1), .alarm(alarm1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int ph, pv, ill, sq, cnt, al);
        exp_t e;
        e.ph = ph; e.pv = pv; e.ill = ill; e.sq = sq; e.cnt = cnt; e.al = al;
        return e;
    endfunction

    // Drive one sample on dut and record the response expected after the next edge.
    task automatic step0(input logic [3:0] cs, input logic clr,
                         input int ph, pv, ill, sq, cnt, al);
        @(negedge clock);
        counter_state = cs;
        clear         = clr;
        q0.push_back(mk(ph, pv, ill, sq, cnt, al));
    endtask

    task automatic step1(input logic [3:0] cs, input logic clr,
                         input int ph, pv, ill, sq, cnt, al);
        @(negedge clock);
        cs1  = cs;
        clr1 = clr;
        q1.push_back(mk(ph, pv, ill, sq, cnt, al));
    endtask

    // Monitors: compare after every rising edge for which a response is owed.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("phase",         32'(phase),         e.ph);
                chk("phase_valid",   32'(phase_valid),   e.pv);
                chk("illegal_state", 32'(illegal_state), e.ill);
                chk("seq_error",     32'(seq_error),     e.sq);
                chk("err_count",     32'(err_count),     e.cnt);
                chk("alarm",         32'(alarm),         e.al);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("sat_phase",         32'(phase1), e.ph);
                chk("sat_phase_valid",   32'(pv1),    e.pv);
                chk("sat_illegal_state", 32'(ill1),   e.ill);
                chk("sat_seq_error",     32'(seq1),   e.sq);
                chk("sat_err_count",     32'(cnt1),   e.cnt);
                chk("sat_alarm",         32'(alarm1), e.al);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_phase"},     32'(phase),         0);
        chk({tag, "_pv"},        32'(phase_valid),   0);
        chk({tag, "_ill"},       32'(illegal_state), 0);
        chk({tag, "_seq"},       32'(seq_error),     0);
        chk({tag, "_cnt"},       32'(err_count),     0);
        chk({tag, "_alarm"},     32'(alarm),         0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] codes [8];
        codes = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                  4'b1111, 4'b1110, 4'b1100, 4'b1000};

        reset = 1'b0; counter_state = 4'b0000; clear = 1'b0;
        cs1 = 4'b0000; clr1 = 1'b0;
        repeat (3) @(negedge clock);
        chk_zero("reset");

        // Clean run: three full wraps, first sample right at release.
        @(negedge clock);
        reset = 1'b1;
        counter_state = codes[0];
        q0.push_back(mk(0, 1, 0, 0, 0, 0));
        for (int i = 1; i < 24; i++)
            step0(codes[i % 8], 1'b0, i % 8, 1, 0, 0, 0, 0);

        // Illegal code after 0011, then 1100 accepted without transition check.
        step0(4'b0000, 0, 0, 1, 0, 0, 0, 0);
        step0(4'b0001, 0, 1, 1, 0, 0, 0, 0);
        step0(4'b0011, 0, 2, 1, 0, 0, 0, 0);
        step0(4'b0101, 0, 2, 0, 1, 0, 1, 0);
        step0(4'b1100, 0, 6, 1, 0, 0, 1, 0);

        // Skip 0011 -> 1111.
        step0(4'b0000, 0, 0, 1, 0, 0, 1, 0);
        step0(4'b0001, 0, 1, 1, 0, 0, 1, 0);
        step0(4'b0011, 0, 2, 1, 0, 0, 1, 0);
        step0(4'b1111, 0, 4, 1, 0, 1, 2, 0);
        step0(4'b1110, 0, 5, 1, 0, 0, 2, 0);

        // 0111 -> 0000 is a legal counter reset.
        step0(4'b0000, 0, 0, 1, 0, 0, 2, 0);
        step0(4'b0001, 0, 1, 1, 0, 0, 2, 0);
        step0(4'b0011, 0, 2, 1, 0, 0, 2, 0);
        step0(4'b0111, 0, 3, 1, 0, 0, 2, 0);
        step0(4'b0000, 0, 0, 1, 0, 0, 2, 0);

        // Repeated 0011: third error raises alarm.
        step0(4'b0001, 0, 1, 1, 0, 0, 2, 0);
        step0(4'b0011, 0, 2, 1, 0, 0, 2, 0);
        step0(4'b0011, 0, 2, 1, 0, 1, 3, 1);

        // 0000 held five cycles, then legal traffic; alarm sticks.
        repeat (5) step0(4'b0000, 0, 0, 1, 0, 0, 3, 1);
        for (int i = 1; i < 8; i++)
            step0(codes[i], 1'b0, i, 1, 0, 0, 3, 1);

        // Clear on a clean sample, then clear coinciding with an illegal code.
        step0(4'b0000, 1, 0, 1, 0, 0, 0, 0);
        step0(4'b0001, 0, 1, 1, 0, 0, 0, 0);
        step0(4'b1010, 1, 1, 0, 1, 0, 1, 0);
        step0(4'b0000, 0, 0, 1, 0, 0, 1, 0);

        // Reach phase 5 with count 2.
        step0(4'b0001, 0, 1, 1, 0, 0, 1, 0);
        step0(4'b0111, 0, 3, 1, 0, 1, 2, 0);
        step0(4'b1111, 0, 4, 1, 0, 0, 2, 0);
        step0(4'b1110, 0, 5, 1, 0, 0, 2, 0);

        // Asynchronous reset between edges.
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clock);
        reset = 1'b1;
        counter_state = 4'b1100;
        q0.push_back(mk(6, 1, 0, 0, 0, 0));
        step0(4'b1000, 0, 7, 1, 0, 0, 0, 0);
        step0(4'b0000, 0, 0, 1, 0, 0, 0, 0);
        step0(4'b1000, 0, 7, 1, 0, 1, 1, 0);

        // Saturation with CNT_W=2.
        step1(4'b0101, 0, 0, 0, 1, 0, 1, 0);
        step1(4'b0110, 0, 0, 0, 1, 0, 2, 0);
        step1(4'b1001, 0, 0, 0, 1, 0, 3, 1);
        step1(4'b1011, 0, 0, 0, 1, 0, 3, 1);
        step1(4'b0100, 0, 0, 0, 1, 0, 3, 1);
        step1(4'b1101, 0, 0, 0, 1, 0, 3, 1);

        for (int i = 0; i < 10 && (q0.size() + q1.size()) > 0; i++)
            @(negedge clock);
        chk("scoreboard_drained", 32'(q0.size() + q1.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
